accel_ctrl_regs: RTL and testbench

AXI4-Lite control slave and register file for an accelerator core. It sits directly downstream of the host-to-AXI-Lite bridge and terminates its s_axi_control channels. It exposes ap_start/ap_done/ap_idle/ap_ready block-level control, scalar kernel arguments, and a level interrupt to the compute core.

---
 rtl/accel_ctrl_pkg.sv | 40 ++++
 rtl/accel_ctrl_regs_if.sv | 37 +++
 rtl/accel_ctrl_regs.sv | 171 +++++++++++++++++
 tb/tb_accel_ctrl_regs.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for the accelerator control slave: register map,
// CTRL/interrupt bit positions, FSM state types and the byte-strobe merge.
package accel_ctrl_pkg;

   localparam int REG_BITS = 32;
   localparam int REG_STRB = REG_BITS / 8;

   localparam int ADDR_CTRL    = 'h00;
   localparam int ADDR_GIE     = 'h04;
   localparam int ADDR_IER     = 'h08;
   localparam int ADDR_ISR     = 'h0C;
   localparam int ADDR_ARG_LEN = 'h10;
   localparam int ADDR_ARG_A   = 'h18;
   localparam int ADDR_ARG_B   = 'h20;

   localparam int CTRL_AP_START     = 0;
   localparam int CTRL_DONE         = 1;
   localparam int CTRL_IDLE         = 2;
   localparam int CTRL_READY        = 3;
   localparam int CTRL_AUTO_RESTART = 7;

   localparam int IRQ_DONE  = 0;
   localparam int IRQ_READY = 1;

   typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
   typedef enum logic       {RIDLE, RDATA}        rstate_t;

   function automatic logic [REG_BITS-1:0] strb_merge(
      input logic [REG_BITS-1:0] old_word,
      input logic [REG_BITS-1:0] new_word,
      input logic [REG_STRB-1:0] strb
   );
      logic [REG_BITS-1:0] merged;
      merged = old_word;
      for (int i = 0; i < REG_STRB; i++)
         if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/accel_ctrl_regs_if.sv
// AXI4-Lite control channel bundle between the host bridge (master)
// and the accelerator register file (slave).
interface accel_ctrl_regs_if #(
   parameter int ADDR_BITS = 6,
   parameter int DATA_BITS = 32,
   parameter int STRB_BITS = DATA_BITS / 8
);

   logic                 AWVALID;
   logic                 AWREADY;
   logic [ADDR_BITS-1:0] AWADDR;
   logic                 WVALID;
   logic                 WREADY;
   logic [DATA_BITS-1:0] WDATA;
   logic [STRB_BITS-1:0] WSTRB;
   logic                 BVALID;
   logic                 BREADY;
   logic [1:0]           BRESP;
   logic                 ARVALID;
   logic                 ARREADY;
   logic [ADDR_BITS-1:0] ARADDR;
   logic                 RVALID;
   logic                 RREADY;
   logic [DATA_BITS-1:0] RDATA;
   logic [1:0]           RRESP;

   modport master (
      output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
      input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
      output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
   );

endinterface

// File: rtl/accel_ctrl_regs.sv
// AXI4-Lite control slave and register file: ap_* block control, scalar
// kernel arguments and a registered level interrupt for the compute core.
module accel_ctrl_regs #(
   parameter int ADDR_BITS = 6,
   parameter int DATA_BITS = 32,
   parameter int STRB_BITS = DATA_BITS / 8
) (
   input  logic                 clock,
   input  logic                 reset_n,
   accel_ctrl_regs_if.slave     s_axi_control,
   output logic                 ap_start,
   input  logic                 ap_done,
   input  logic                 ap_idle,
   input  logic                 ap_ready,
   output logic [DATA_BITS-1:0] arg_len,
   output logic [DATA_BITS-1:0] arg_a,
   output logic [DATA_BITS-1:0] arg_b,
   output logic                 interrupt
);

   import accel_ctrl_pkg::*;

   localparam logic [ADDR_BITS-1:0] WORD_MASK = ~ADDR_BITS'(3);

   // Address low bits select a byte lane only; registers decode on the word.
   function automatic logic hit(input logic [ADDR_BITS-1:0] addr, input int offset);
      return (addr & WORD_MASK) == ADDR_BITS'(offset);
   endfunction

   wstate_t              wstate;
   rstate_t              rstate;
   logic [ADDR_BITS-1:0] waddr;
   logic [DATA_BITS-1:0] wdata;
   logic [STRB_BITS-1:0] wstrb;
   logic [DATA_BITS-1:0] rd_mux;
   logic                 wcommit, rhs;
   logic                 wr_ctrl, wr_gie, wr_ier, wr_isr, rd_ctrl;
   logic                 done_s, ready_s, auto_restart, gie;
   logic [1:0]           ier, isr;

   assign wdata   = s_axi_control.WDATA;
   assign wstrb   = s_axi_control.WSTRB;
   assign wcommit = (wstate == WDATA) && s_axi_control.WVALID;
   assign rhs     = (rstate == RIDLE) && s_axi_control.ARVALID;

   assign wr_ctrl = wcommit && wstrb[0] && hit(waddr, ADDR_CTRL);
   assign wr_gie  = wcommit && wstrb[0] && hit(waddr, ADDR_GIE);
   assign wr_ier  = wcommit && wstrb[0] && hit(waddr, ADDR_IER);
   assign wr_isr  = wcommit && wstrb[0] && hit(waddr, ADDR_ISR);
   assign rd_ctrl = rhs && hit(s_axi_control.ARADDR, ADDR_CTRL);

   assign s_axi_control.BRESP = 2'b00;
   assign s_axi_control.RRESP = 2'b00;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wstate                <= WIDLE;
         waddr                 <= '0;
         s_axi_control.AWREADY <= 1'b1;
         s_axi_control.WREADY  <= 1'b0;
         s_axi_control.BVALID  <= 1'b0;
      end else begin
         case (wstate)
            WIDLE: if (s_axi_control.AWVALID) begin
               waddr                 <= s_axi_control.AWADDR;
               s_axi_control.AWREADY <= 1'b0;
               s_axi_control.WREADY  <= 1'b1;
               wstate                <= WDATA;
            end
            WDATA: if (s_axi_control.WVALID) begin
               s_axi_control.WREADY <= 1'b0;
               s_axi_control.BVALID <= 1'b1;
               wstate               <= WRESP;
            end
            WRESP: if (s_axi_control.BREADY) begin
               s_axi_control.BVALID  <= 1'b0;
               s_axi_control.AWREADY <= 1'b1;
               wstate                <= WIDLE;
            end
            default: begin
               s_axi_control.AWREADY <= 1'b1;
               s_axi_control.WREADY  <= 1'b0;
               s_axi_control.BVALID  <= 1'b0;
               wstate                <= WIDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      if (hit(s_axi_control.ARADDR, ADDR_CTRL)) begin
         rd_mux[CTRL_AP_START]     = ap_start;
         rd_mux[CTRL_DONE]         = done_s;
         rd_mux[CTRL_IDLE]         = ap_idle;
         rd_mux[CTRL_READY]        = ready_s;
         rd_mux[CTRL_AUTO_RESTART] = auto_restart;
      end else if (hit(s_axi_control.ARADDR, ADDR_GIE))     rd_mux[0]   = gie;
      else if (hit(s_axi_control.ARADDR, ADDR_IER))         rd_mux[1:0] = ier;
      else if (hit(s_axi_control.ARADDR, ADDR_ISR))         rd_mux[1:0] = isr;
      else if (hit(s_axi_control.ARADDR, ADDR_ARG_LEN))     rd_mux      = arg_len;
      else if (hit(s_axi_control.ARADDR, ADDR_ARG_A))       rd_mux      = arg_a;
      else if (hit(s_axi_control.ARADDR, ADDR_ARG_B))       rd_mux      = arg_b;
   end

   // RDATA is captured at the AR handshake, so a same-cycle write commit is not visible.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rstate                <= RIDLE;
         s_axi_control.ARREADY <= 1'b1;
         s_axi_control.RVALID  <= 1'b0;
         s_axi_control.RDATA   <= '0;
      end else begin
         case (rstate)
            RIDLE: if (s_axi_control.ARVALID) begin
               s_axi_control.RDATA   <= rd_mux;
               s_axi_control.RVALID  <= 1'b1;
               s_axi_control.ARREADY <= 1'b0;
               rstate                <= RDATA;
            end
            RDATA: if (s_axi_control.RREADY) begin
               s_axi_control.RVALID  <= 1'b0;
               s_axi_control.ARREADY <= 1'b1;
               rstate                <= RIDLE;
            end
            default: begin
               s_axi_control.RVALID  <= 1'b0;
               s_axi_control.ARREADY <= 1'b1;
               rstate                <= RIDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ap_start     <= 1'b0;
         auto_restart <= 1'b0;
         done_s       <= 1'b0;
         ready_s      <= 1'b0;
         gie          <= 1'b0;
         ier          <= '0;
         isr          <= '0;
         arg_len      <= '0;
         arg_a        <= '0;
         arg_b        <= '0;
         interrupt    <= 1'b0;
      end else begin
         if (wr_ctrl && wdata[CTRL_AP_START]) ap_start <= 1'b1;
         else if (ap_ready && !auto_restart)  ap_start <= 1'b0;
         if (wr_ctrl) auto_restart <= wdata[CTRL_AUTO_RESTART];

         if (ap_done)      done_s <= 1'b1;
         else if (rd_ctrl) done_s <= 1'b0;
         if (ap_ready)     ready_s <= 1'b1;
         else if (rd_ctrl) ready_s <= 1'b0;

         if (wr_gie) gie <= wdata[0];
         if (wr_ier) ier <= wdata[1:0];
         // Hardware set is OR-ed after the host toggle so it always wins.
         isr <= (isr ^ (wr_isr ? wdata[1:0] : 2'b00)) | ({ap_ready, ap_done} & ier);

         if (wcommit && hit(waddr, ADDR_ARG_LEN)) arg_len <= strb_merge(arg_len, wdata, wstrb);
         if (wcommit && hit(waddr, ADDR_ARG_A))   arg_a   <= strb_merge(arg_a, wdata, wstrb);
         if (wcommit && hit(waddr, ADDR_ARG_B))   arg_b   <= strb_merge(arg_b, wdata, wstrb);

         interrupt <= gie && |(ier & isr);
      end
   end

endmodule

// File: tb/tb_accel_ctrl_regs.sv
// Bench for accel_ctrl_regs: directed scenarios plus randomized AXI-Lite
// traffic and core pulses compared against a register-level reference model.
module tb_accel_ctrl_regs;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ap_start, interrupt;
   logic        ap_done = 1'b0, ap_idle = 1'b1, ap_ready = 1'b0;
   logic [31:0] arg_len, arg_a, arg_b;

   accel_ctrl_regs_if #(.ADDR_BITS(6), .DATA_BITS(32)) s_axi_control ();

   accel_ctrl_regs #(.ADDR_BITS(6), .DATA_BITS(32)) dut (
      .clock(clock), .reset_n(reset_n), .s_axi_control(s_axi_control),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .arg_len(arg_len), .arg_a(arg_a), .arg_b(arg_b), .interrupt(interrupt)
   );

   always #5 clock = ~clock;

   int checks = 0, errors = 0;

   // Reference model: architectural register contents.
   logic        m_start, m_done_s, m_ready_s, m_auto, m_gie;
   logic [1:0]  m_ier, m_isr;
   logic [31:0] m_arg [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_start = 0; m_done_s = 0; m_ready_s = 0; m_auto = 0; m_gie = 0;
      m_ier = 0; m_isr = 0;
      foreach (m_arg[i]) m_arg[i] = 0;
   endtask

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [5:0] addr);
      case (addr & 6'h3C)
         6'h00:   return {24'b0, m_auto, 3'b0, m_ready_s, ap_idle, m_done_s, m_start};
         6'h04:   return {31'b0, m_gie};
         6'h08:   return {30'b0, m_ier};
         6'h0C:   return {30'b0, m_isr};
         6'h10:   return m_arg[0];
         6'h18:   return m_arg[1];
         6'h20:   return m_arg[2];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic model_irq();
      return m_gie && ((m_ier & m_isr) != 2'b00);
   endfunction

   // Core pulses seen on an edge; old_* are the register values before that edge.
   task automatic model_pulse(input logic pd, input logic pr, input logic old_auto,
                              input logic [1:0] old_ier, input logic host_set);
      if (pd) begin
         m_done_s = 1;
         if (old_ier[0]) m_isr[0] = 1;
      end
      if (pr) begin
         m_ready_s = 1;
         if (old_ier[1]) m_isr[1] = 1;
         if (!old_auto && !host_set) m_start = 0;
      end
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic pd, input logic pr, input int bdelay);
      int n;
      logic old_auto, host_set;
      logic [1:0] old_ier;
      s_axi_control.AWADDR = addr;
      s_axi_control.AWVALID = 1;
      n = 0;
      while (!s_axi_control.AWREADY && n < 20) begin step(); n++; end
      chk("awready", s_axi_control.AWREADY, 1);
      step();
      s_axi_control.AWVALID = 0;
      s_axi_control.WDATA = data;
      s_axi_control.WSTRB = strb;
      s_axi_control.WVALID = 1;
      n = 0;
      while (!s_axi_control.WREADY && n < 20) begin step(); n++; end
      chk("wready", s_axi_control.WREADY, 1);
      ap_done = pd;
      ap_ready = pr;
      old_auto = m_auto;
      old_ier = m_ier;
      host_set = 0;
      step();
      s_axi_control.WVALID = 0;
      ap_done = 0;
      ap_ready = 0;
      case (addr & 6'h3C)
         6'h00: if (strb[0]) begin
            if (data[0]) begin m_start = 1; host_set = 1; end
            m_auto = data[7];
         end
         6'h04: if (strb[0]) m_gie = data[0];
         6'h08: if (strb[0]) m_ier = data[1:0];
         6'h0C: if (strb[0]) m_isr = m_isr ^ data[1:0];
         6'h10: m_arg[0] = byte_merge(m_arg[0], data, strb);
         6'h18: m_arg[1] = byte_merge(m_arg[1], data, strb);
         6'h20: m_arg[2] = byte_merge(m_arg[2], data, strb);
         default: ;
      endcase
      model_pulse(pd, pr, old_auto, old_ier, host_set);
      chk("bvalid", s_axi_control.BVALID, 1);
      for (int i = 0; i < bdelay; i++) begin
         step();
         chk("bvalid_hold", s_axi_control.BVALID, 1);
      end
      chk("bresp", s_axi_control.BRESP, 0);
      s_axi_control.BREADY = 1;
      step();
      s_axi_control.BREADY = 0;
      chk("bvalid_drop", s_axi_control.BVALID, 0);
   endtask

   task automatic axi_read(input logic [5:0] addr, input int hold, input logic pd, input logic pr,
                           output logic [31:0] data);
      int n;
      logic [31:0] exp;
      logic old_auto;
      logic [1:0] old_ier;
      s_axi_control.ARADDR = addr;
      s_axi_control.ARVALID = 1;
      n = 0;
      while (!s_axi_control.ARREADY && n < 20) begin step(); n++; end
      chk("arready", s_axi_control.ARREADY, 1);
      chk("rvalid_pre", s_axi_control.RVALID, 0);
      exp = model_rd(addr);
      ap_done = pd;
      ap_ready = pr;
      old_auto = m_auto;
      old_ier = m_ier;
      step();
      s_axi_control.ARVALID = 0;
      ap_done = 0;
      ap_ready = 0;
      if ((addr & 6'h3C) == 6'h00) begin m_done_s = 0; m_ready_s = 0; end
      model_pulse(pd, pr, old_auto, old_ier, 0);
      chk("rvalid_lat", s_axi_control.RVALID, 1);
      chk("rdata", s_axi_control.RDATA, exp);
      chk("rresp", s_axi_control.RRESP, 0);
      data = s_axi_control.RDATA;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("rvalid_hold", s_axi_control.RVALID, 1);
         chk("rdata_hold", s_axi_control.RDATA, exp);
         chk("arready_busy", s_axi_control.ARREADY, 0);
      end
      s_axi_control.RREADY = 1;
      step();
      s_axi_control.RREADY = 0;
      chk("rvalid_drop", s_axi_control.RVALID, 0);
      chk("arready_back", s_axi_control.ARREADY, 1);
   endtask

   task automatic pulse(input logic pd, input logic pr);
      ap_done = pd;
      ap_ready = pr;
      step();
      ap_done = 0;
      ap_ready = 0;
      model_pulse(pd, pr, m_auto, m_ier, 0);
   endtask

   task automatic check_state(input string tag);
      step();
      chk({tag, "_ap_start"}, ap_start, m_start);
      chk({tag, "_irq"}, interrupt, model_irq());
      chk({tag, "_arg_len"}, arg_len, m_arg[0]);
      chk({tag, "_arg_a"}, arg_a, m_arg[1]);
      chk({tag, "_arg_b"}, arg_b, m_arg[2]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic [5:0]  addr_tbl [11];
      logic [5:0]  a;
      logic [31:0] d;
      int          op;

      addr_tbl = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h18, 6'h20, 6'h14, 6'h1C, 6'h24, 6'h3C};
      s_axi_control.AWVALID = 0; s_axi_control.AWADDR = 0;
      s_axi_control.WVALID = 0;  s_axi_control.WDATA = 0; s_axi_control.WSTRB = 0;
      s_axi_control.BREADY = 0;
      s_axi_control.ARVALID = 0; s_axi_control.ARADDR = 0; s_axi_control.RREADY = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 reset_n = 1;

      chk("rst_awready", s_axi_control.AWREADY, 1);
      chk("rst_arready", s_axi_control.ARREADY, 1);
      chk("rst_bvalid", s_axi_control.BVALID, 0);
      chk("rst_rvalid", s_axi_control.RVALID, 0);
      chk("rst_rdata", s_axi_control.RDATA, 0);
      check_state("rst");
      axi_read(6'h10, 0, 0, 0, rd);
      chk("rst_read_len", rd, 32'h0);

      // Byte-masked argument write.
      axi_write(6'h10, 32'h11223344, 4'hF, 0, 0, 0);
      axi_write(6'h10, 32'hDEADBEEF, 4'b0011, 0, 0, 1);
      chk("arg_len_merge", arg_len, 32'h1122BEEF);
      axi_read(6'h12, 0, 0, 0, rd);
      chk("arg_len_readback", rd, 32'h1122BEEF);

      // ap_start set/clear, with and without auto_restart.
      axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0);
      chk("ap_start_set", ap_start, 1);
      pulse(0, 1);
      chk("ap_start_clr", ap_start, 0);
      axi_write(6'h00, 32'h81, 4'h1, 0, 0, 0);
      pulse(0, 1);
      chk("ap_start_auto", ap_start, 1);
      axi_write(6'h00, 32'h0, 4'h1, 0, 0, 0);
      chk("ap_start_wr0", ap_start, 1);
      pulse(0, 1);
      chk("ap_start_clr2", ap_start, 0);
      axi_write(6'h00, 32'h1, 4'h1, 0, 1, 0);
      chk("ap_start_set_wins", ap_start, 1);
      axi_read(6'h00, 0, 0, 0, rd);
      check_state("ctrl");

      // Interrupt path and clear-on-read done bit.
      axi_write(6'h04, 32'h1, 4'h1, 0, 0, 0);
      axi_write(6'h08, 32'h1, 4'h1, 0, 0, 0);
      pulse(1, 0);
      check_state("irq_on");
      chk("irq_set", interrupt, 1);
      axi_read(6'h00, 0, 0, 0, rd);
      chk("ctrl_done_1", rd[1], 1);
      axi_read(6'h00, 0, 0, 0, rd);
      chk("ctrl_done_0", rd[1], 0);
      axi_read(6'h00, 0, 1, 0, rd);
      chk("done_set_wins_rd", rd[1], 0);
      axi_read(6'h00, 0, 0, 0, rd);
      chk("done_set_wins", rd[1], 1);
      axi_write(6'h0C, 32'h1, 4'h1, 0, 0, 0);
      check_state("irq_clr");
      chk("irq_cleared", interrupt, 0);
      axi_write(6'h0C, 32'h1, 4'h1, 1, 0, 0);
      check_state("isr_set_wins");

      // Stalled read response.
      axi_read(6'h18, 5, 0, 0, rd);

      // Randomized traffic.
      for (int it = 0; it < 200; it++) begin
         ap_idle = 1'($urandom_range(0, 1));
         a = addr_tbl[$urandom_range(0, 10)] | 6'($urandom_range(0, 3));
         op = $urandom_range(0, 9);
         if (op < 4) begin
            d = $urandom();
            axi_write(a, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
         end else if (op < 8) begin
            axi_read(a, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), rd);
         end else if (op == 8) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            check_state("rand");
         end
      end
      check_state("rand_end");

      // Reset while the write response is pending.
      s_axi_control.AWADDR = 6'h18;
      s_axi_control.AWVALID = 1;
      step();
      s_axi_control.AWVALID = 0;
      s_axi_control.WDATA = 32'hCAFEF00D;
      s_axi_control.WSTRB = 4'hF;
      s_axi_control.WVALID = 1;
      step();
      s_axi_control.WVALID = 0;
      chk("wresp_bvalid", s_axi_control.BVALID, 1);
      chk("wresp_arg_a", arg_a, 32'hCAFEF00D);
      #2 reset_n = 0;
      #1;
      model_reset();
      chk("arst_bvalid", s_axi_control.BVALID, 0);
      chk("arst_arg_len", arg_len, 0);
      chk("arst_arg_a", arg_a, 0);
      chk("arst_arg_b", arg_b, 0);
      chk("arst_ap_start", ap_start, 0);
      chk("arst_irq", interrupt, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1;
      chk("arst_awready", s_axi_control.AWREADY, 1);
      chk("arst_arready", s_axi_control.ARREADY, 1);
      axi_read(6'h18, 0, 0, 0, rd);
      check_state("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
